// File: rtl/axi_lite_router_pkg.sv
// Shared constants, FSM state types and the address decode helper for the
// picorv32 AXI4-lite router.
package axi_lite_router_pkg;

  // Default memory map: 128 KiB RAM at 0, MMIO window 0x1000_0000..0x2FFF_FFFF
  localparam logic [31:0] DEF_MEM_BASE    = 32'h0000_0000;
  localparam logic [31:0] DEF_MEM_SIZE    = 32'h0002_0000;
  localparam logic [31:0] DEF_PERIPH_BASE = 32'h1000_0000;
  localparam logic [31:0] DEF_PERIPH_SIZE = 32'h2000_0000;
  localparam logic [31:0] DEF_ERR_RDATA   = 32'h0000_0000;

  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_ERR} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} wr_state_t;

  // Returns {hit0, hit1}; region 0 wins when the two windows overlap.
  // Subtract-then-compare keeps the test a single unsigned range check.
  function automatic logic [1:0] decode(input logic [31:0] addr,
                                        input logic [31:0] base0,
                                        input logic [31:0] size0,
                                        input logic [31:0] base1,
                                        input logic [31:0] size1);
    logic hit0, hit1;
    hit0 = (addr - base0) < size0;
    hit1 = !hit0 && ((addr - base1) < size1);
    return {hit0, hit1};
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-lite bundle (no resp fields). master drives requests, slave answers.
interface axi_lite_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );
endinterface

// File: rtl/axi_lite_addr_decode.sv
// Combinational address decode: which slave (0/1) and whether mapped at all.
module axi_lite_addr_decode
  import axi_lite_router_pkg::*;
#(
  parameter logic [31:0] MEM_BASE    = DEF_MEM_BASE,
  parameter logic [31:0] MEM_SIZE    = DEF_MEM_SIZE,
  parameter logic [31:0] PERIPH_BASE = DEF_PERIPH_BASE,
  parameter logic [31:0] PERIPH_SIZE = DEF_PERIPH_SIZE
) (
  input  logic [31:0] addr,
  output logic        sel,
  output logic        mapped
);
  logic [1:0] hits;

  assign hits   = decode(addr, MEM_BASE, MEM_SIZE, PERIPH_BASE, PERIPH_SIZE);
  assign sel    = hits[0];
  assign mapped = |hits;
endmodule

// File: rtl/axi_lite_router.sv
// 1-master / 2-slave AXI4-lite router. Independent read and write FSMs, one
// outstanding transaction each; unmapped accesses are answered locally.
module axi_lite_router
  import axi_lite_router_pkg::*;
#(
  parameter logic [31:0] MEM_BASE    = DEF_MEM_BASE,
  parameter logic [31:0] MEM_SIZE    = DEF_MEM_SIZE,
  parameter logic [31:0] PERIPH_BASE = DEF_PERIPH_BASE,
  parameter logic [31:0] PERIPH_SIZE = DEF_PERIPH_SIZE,
  parameter logic [31:0] ERR_RDATA   = DEF_ERR_RDATA
) (
  input  logic        clk,
  input  logic        resetn,
  axi_lite_if.slave   m,
  axi_lite_if.master  s0,
  axi_lite_if.master  s1,
  output logic        decode_err,
  output logic [31:0] err_addr,
  output logic        err_is_write
);

  logic ar_sel, ar_mapped, aw_sel, aw_mapped;

  axi_lite_addr_decode #(.MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE),
                         .PERIPH_BASE(PERIPH_BASE), .PERIPH_SIZE(PERIPH_SIZE))
    u_ar_dec (.addr(m.araddr), .sel(ar_sel), .mapped(ar_mapped));

  axi_lite_addr_decode #(.MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE),
                         .PERIPH_BASE(PERIPH_BASE), .PERIPH_SIZE(PERIPH_SIZE))
    u_aw_dec (.addr(m.awaddr), .sel(aw_sel), .mapped(aw_mapped));

  // ---------------------------------------------------------------- read
  rd_state_t   r_state, r_next;
  logic        ar_pulse, ar_fwd, r_sel;
  logic [31:0] r_addr;
  logic [2:0]  r_prot;
  logic        sel_arready, sel_rvalid;
  logic [31:0] sel_rdata;

  assign sel_arready = r_sel ? s1.arready : s0.arready;
  assign sel_rvalid  = r_sel ? s1.rvalid  : s0.rvalid;
  assign sel_rdata   = r_sel ? s1.rdata   : s0.rdata;
  assign m.arready   = ar_pulse;
  assign s0.araddr   = r_addr;
  assign s0.arprot   = r_prot;
  assign s1.araddr   = r_addr;
  assign s1.arprot   = r_prot;

  // Read state register
  always_ff @(posedge clk)
    if (!resetn) r_state <= R_IDLE;
    else         r_state <= r_next;

  // Read next state and per-state channel steering
  always_comb begin
    r_next     = r_state;
    m.rvalid   = 1'b0;
    m.rdata    = ERR_RDATA;
    s0.arvalid = 1'b0;
    s1.arvalid = 1'b0;
    s0.rready  = 1'b0;
    s1.rready  = 1'b0;
    case (r_state)
      R_IDLE: if (m.arvalid) r_next = ar_mapped ? R_FWD : R_ERR;
      R_FWD: begin
        s0.arvalid = ar_fwd & ~r_sel;
        s1.arvalid = ar_fwd &  r_sel;
        if (ar_fwd && sel_arready) r_next = R_RESP;
      end
      R_RESP: begin
        m.rvalid  = sel_rvalid;
        m.rdata   = sel_rdata;
        s0.rready = m.rready & ~r_sel;
        s1.rready = m.rready &  r_sel;
        if (sel_rvalid && m.rready) r_next = R_IDLE;
      end
      R_ERR: begin
        // hold the local response back until the AR handshake has completed
        m.rvalid = ~ar_pulse;
        if (!ar_pulse && m.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read accept pulse, request latch and registered forward valid
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ar_pulse <= 1'b0;
      ar_fwd   <= 1'b0;
      r_sel    <= 1'b0;
      r_addr   <= '0;
      r_prot   <= '0;
    end else begin
      ar_pulse <= (r_state == R_IDLE) && m.arvalid;
      if (r_state == R_IDLE && m.arvalid) begin
        r_addr <= m.araddr;
        r_prot <= m.arprot;
        r_sel  <= ar_sel;
      end
      if (r_state == R_FWD) begin
        if (ar_pulse)                    ar_fwd <= 1'b1;
        else if (ar_fwd && sel_arready)  ar_fwd <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------- write
  wr_state_t   w_state, w_next;
  logic        aw_pulse, w_fwd, aw_done, w_done, w_sel;
  logic [31:0] w_addr, w_data;
  logic [2:0]  w_prot;
  logic [3:0]  w_strb;
  logic        sel_awready, sel_wready, sel_bvalid;
  logic        aw_vld, wd_vld, aw_hs, w_hs;

  assign sel_awready = w_sel ? s1.awready : s0.awready;
  assign sel_wready  = w_sel ? s1.wready  : s0.wready;
  assign sel_bvalid  = w_sel ? s1.bvalid  : s0.bvalid;
  assign aw_vld      = (w_state == W_FWD) & w_fwd & ~aw_done;
  assign wd_vld      = (w_state == W_FWD) & w_fwd & ~w_done;
  assign aw_hs       = aw_vld & sel_awready;
  assign w_hs        = wd_vld & sel_wready;
  assign m.awready   = aw_pulse;
  assign m.wready    = aw_pulse;
  assign s0.awaddr   = w_addr;
  assign s0.awprot   = w_prot;
  assign s0.wdata    = w_data;
  assign s0.wstrb    = w_strb;
  assign s1.awaddr   = w_addr;
  assign s1.awprot   = w_prot;
  assign s1.wdata    = w_data;
  assign s1.wstrb    = w_strb;
  assign s0.awvalid  = aw_vld & ~w_sel;
  assign s1.awvalid  = aw_vld &  w_sel;
  assign s0.wvalid   = wd_vld & ~w_sel;
  assign s1.wvalid   = wd_vld &  w_sel;

  // Write state register
  always_ff @(posedge clk)
    if (!resetn) w_state <= W_IDLE;
    else         w_state <= w_next;

  // Write next state and B-channel steering
  always_comb begin
    w_next    = w_state;
    m.bvalid  = 1'b0;
    s0.bready = 1'b0;
    s1.bready = 1'b0;
    case (w_state)
      W_IDLE: if (m.awvalid && m.wvalid) w_next = aw_mapped ? W_FWD : W_ERR;
      W_FWD:  if (w_fwd && (aw_done || aw_hs) && (w_done || w_hs)) w_next = W_RESP;
      W_RESP: begin
        m.bvalid  = sel_bvalid;
        s0.bready = m.bready & ~w_sel;
        s1.bready = m.bready &  w_sel;
        if (sel_bvalid && m.bready) w_next = W_IDLE;
      end
      W_ERR: begin
        m.bvalid = ~aw_pulse;
        if (!aw_pulse && m.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write accept pulse, request latch and per-channel done tracking
  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_pulse <= 1'b0;
      w_fwd    <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      w_sel    <= 1'b0;
      w_addr   <= '0;
      w_data   <= '0;
      w_prot   <= '0;
      w_strb   <= '0;
    end else begin
      aw_pulse <= (w_state == W_IDLE) && m.awvalid && m.wvalid;
      if (w_state == W_IDLE && m.awvalid && m.wvalid) begin
        w_addr <= m.awaddr;
        w_prot <= m.awprot;
        w_data <= m.wdata;
        w_strb <= m.wstrb;
        w_sel  <= aw_sel;
      end
      if (w_state == W_FWD) begin
        if (aw_pulse) w_fwd   <= 1'b1;
        if (aw_hs)    aw_done <= 1'b1;
        if (w_hs)     w_done  <= 1'b1;
        if (w_next == W_RESP) begin
          w_fwd   <= 1'b0;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------- error capture
  logic rd_err_entry, wr_err_entry;

  assign rd_err_entry = (r_state == R_IDLE) && (r_next == R_ERR);
  assign wr_err_entry = (w_state == W_IDLE) && (w_next == W_ERR);

  // Sticky record of the first unmapped access; writes win a same-cycle tie
  always_ff @(posedge clk) begin
    if (!resetn) begin
      decode_err   <= 1'b0;
      err_addr     <= '0;
      err_is_write <= 1'b0;
    end else if (!decode_err && (wr_err_entry || rd_err_entry)) begin
      decode_err   <= 1'b1;
      err_is_write <= wr_err_entry;
      err_addr     <= wr_err_entry ? m.awaddr : m.araddr;
    end
  end

endmodule

// File: tb/tb_axi_lite_router.sv
// Directed bench for axi_lite_router: routing, boundary decode, error capture,
// concurrency, backpressure and mid-transaction reset.
module tb_axi_lite_router;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        decode_err;
  logic [31:0] err_addr;
  logic        err_is_write;

  int checks = 0;
  int failures = 0;
  int s0_rd_act = 0, s0_wr_act = 0, s1_rd_act = 0, s1_wr_act = 0;
  int r_xfers = 0, b_xfers = 0;

  axi_lite_if m_bus();
  axi_lite_if s0_bus();
  axi_lite_if s1_bus();

  axi_lite_router dut (
    .clk(clk), .resetn(resetn), .m(m_bus), .s0(s0_bus), .s1(s1_bus),
    .decode_err(decode_err), .err_addr(err_addr), .err_is_write(err_is_write)
  );

  always #5 clk = ~clk;

  // per-slave activity: any cycle the router drives a valid/ready toward it
  always @(negedge clk) begin
    if (s0_bus.arvalid || s0_bus.rready) s0_rd_act++;
    if (s0_bus.awvalid || s0_bus.wvalid || s0_bus.bready) s0_wr_act++;
    if (s1_bus.arvalid || s1_bus.rready) s1_rd_act++;
    if (s1_bus.awvalid || s1_bus.wvalid || s1_bus.bready) s1_wr_act++;
  end

  // completed master-side response beats
  always @(posedge clk) begin
    if (m_bus.rvalid && m_bus.rready) r_xfers++;
    if (m_bus.bvalid && m_bus.bready) b_xfers++;
  end

  function automatic logic [14:0] hs_outs();
    return {m_bus.arready, m_bus.awready, m_bus.wready, m_bus.rvalid, m_bus.bvalid,
            s0_bus.arvalid, s0_bus.awvalid, s0_bus.wvalid, s0_bus.rready, s0_bus.bready,
            s1_bus.arvalid, s1_bus.awvalid, s1_bus.wvalid, s1_bus.rready, s1_bus.bready};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_ar(input logic [31:0] a, output bit ok);
    ok = 1'b0;
    m_bus.arvalid = 1'b1; m_bus.araddr = a; m_bus.arprot = 3'b000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_bus.arready) begin ok = 1'b1; break; end
    end
    step();
    m_bus.arvalid = 1'b0;
  endtask

  task automatic m_aw(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output bit ok);
    ok = 1'b0;
    m_bus.awvalid = 1'b1; m_bus.awaddr = a; m_bus.awprot = 3'b000;
    m_bus.wvalid = 1'b1; m_bus.wdata = d; m_bus.wstrb = s;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_bus.awready && m_bus.wready) begin ok = 1'b1; break; end
    end
    step();
    m_bus.awvalid = 1'b0; m_bus.wvalid = 1'b0;
  endtask

  task automatic s_ar_accept(input int idx, output logic [31:0] a, output bit ok);
    ok = 1'b0; a = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (idx == 0 && s0_bus.arvalid) begin
        ok = 1'b1; a = s0_bus.araddr; s0_bus.arready = 1'b1; break;
      end
      if (idx == 1 && s1_bus.arvalid) begin
        ok = 1'b1; a = s1_bus.araddr; s1_bus.arready = 1'b1; break;
      end
    end
    step();
    s0_bus.arready = 1'b0; s1_bus.arready = 1'b0;
  endtask

  task automatic s_aw_accept(input int idx, output logic [31:0] a,
                             output logic [31:0] d, output logic [3:0] s, output bit ok);
    ok = 1'b0; a = '0; d = '0; s = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (idx == 0 && s0_bus.awvalid && s0_bus.wvalid) begin
        ok = 1'b1; a = s0_bus.awaddr; d = s0_bus.wdata; s = s0_bus.wstrb;
        s0_bus.awready = 1'b1; s0_bus.wready = 1'b1; break;
      end
      if (idx == 1 && s1_bus.awvalid && s1_bus.wvalid) begin
        ok = 1'b1; a = s1_bus.awaddr; d = s1_bus.wdata; s = s1_bus.wstrb;
        s1_bus.awready = 1'b1; s1_bus.wready = 1'b1; break;
      end
    end
    step();
    s0_bus.awready = 1'b0; s0_bus.wready = 1'b0;
    s1_bus.awready = 1'b0; s1_bus.wready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if (hs_outs() !== 15'd0) begin
      failures++; $display("FAIL reset_handshakes: got %b expected %b", hs_outs(), 15'd0);
    end
    checks++;
    if ({decode_err, err_addr, err_is_write} !== 34'd0) begin
      failures++; $display("FAIL reset_err: got %b/%h/%b expected 0/0/0", decode_err, err_addr, err_is_write);
    end
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_read();
    bit ok1, ok2; logic [31:0] a; int s1b;
    s1b = s1_rd_act + s1_wr_act;
    m_bus.rready = 1'b1;
    m_ar(32'h0000_0100, ok1);
    s_ar_accept(0, a, ok2);
    checks++;
    if (!ok1 || !ok2 || a !== 32'h0000_0100) begin
      failures++; $display("FAIL read_fwd: got ok=%0d/%0d addr=%h expected 1/1 addr=00000100", ok1, ok2, a);
    end
    step(); step();
    s0_bus.rvalid = 1'b1; s0_bus.rdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (m_bus.rvalid !== 1'b1 || m_bus.rdata !== 32'h1234_5678 || s0_bus.rready !== 1'b1) begin
      failures++; $display("FAIL read_resp: got v=%b d=%h rr=%b expected 1 12345678 1", m_bus.rvalid, m_bus.rdata, s0_bus.rready);
    end
    step();
    s0_bus.rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (m_bus.rvalid !== 1'b0 || decode_err !== 1'b0 || (s1_rd_act + s1_wr_act) != s1b) begin
      failures++; $display("FAIL read_after: got v=%b err=%b s1act=%0d expected 0 0 %0d", m_bus.rvalid, decode_err, s1_rd_act + s1_wr_act, s1b);
    end
  endtask

  task automatic test_write();
    bit ok1, ok2; logic [31:0] a, d; logic [3:0] s; int s0b;
    s0b = s0_rd_act + s0_wr_act;
    m_bus.bready = 1'b1;
    m_aw(32'h1000_0000, 32'h0000_0041, 4'b0001, ok1);
    s_aw_accept(1, a, d, s, ok2);
    checks++;
    if (!ok1 || !ok2 || a !== 32'h1000_0000 || d !== 32'h41 || s !== 4'b0001) begin
      failures++; $display("FAIL write_fwd: got ok=%0d/%0d a=%h d=%h s=%b expected 10000000 00000041 0001", ok1, ok2, a, d, s);
    end
    step();
    s1_bus.bvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (m_bus.bvalid !== 1'b1 || s1_bus.bready !== 1'b1) begin
      failures++; $display("FAIL write_bpass: got bvalid=%b bready=%b expected 1 1", m_bus.bvalid, s1_bus.bready);
    end
    step();
    s1_bus.bvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (m_bus.bvalid !== 1'b0 || (s0_rd_act + s0_wr_act) != s0b) begin
      failures++; $display("FAIL write_after: got bvalid=%b s0act=%0d expected 0 %0d", m_bus.bvalid, s0_rd_act + s0_wr_act, s0b);
    end
  endtask

  task automatic test_boundary();
    bit ok1, ok2; logic [31:0] a; int act;
    m_bus.rready = 1'b1; m_bus.bready = 1'b1;
    m_ar(32'h0001_FFFC, ok1);
    s_ar_accept(0, a, ok2);
    checks++;
    if (!ok1 || !ok2 || a !== 32'h0001_FFFC) begin
      failures++; $display("FAIL bound_last_ram: got ok=%0d/%0d a=%h expected s0 0001fffc", ok1, ok2, a);
    end
    s0_bus.rvalid = 1'b1; s0_bus.rdata = 32'h0BAD_0001;
    step();
    s0_bus.rvalid = 1'b0;
    act = s0_rd_act + s0_wr_act + s1_rd_act + s1_wr_act;
    m_ar(32'h0002_0000, ok1);
    @(negedge clk);
    checks++;
    if (!ok1 || m_bus.rvalid !== 1'b1 || m_bus.rdata !== 32'h0) begin
      failures++; $display("FAIL bound_err_resp: got ok=%0d v=%b d=%h expected 1 1 00000000", ok1, m_bus.rvalid, m_bus.rdata);
    end
    checks++;
    if (decode_err !== 1'b1 || err_addr !== 32'h0002_0000 || err_is_write !== 1'b0) begin
      failures++; $display("FAIL bound_err_cap: got %b/%h/%b expected 1/00020000/0", decode_err, err_addr, err_is_write);
    end
    step();
    @(negedge clk);
    checks++;
    if (m_bus.rvalid !== 1'b0 || (s0_rd_act + s0_wr_act + s1_rd_act + s1_wr_act) != act) begin
      failures++; $display("FAIL bound_no_slave: got v=%b act=%0d expected 0 %0d", m_bus.rvalid, s0_rd_act + s0_wr_act + s1_rd_act + s1_wr_act, act);
    end
    m_aw(32'h3000_0000, 32'h1, 4'hF, ok1);
    @(negedge clk);
    checks++;
    if (!ok1 || m_bus.bvalid !== 1'b1) begin
      failures++; $display("FAIL bound_werr_resp: got ok=%0d bvalid=%b expected 1 1", ok1, m_bus.bvalid);
    end
    step();
    @(negedge clk);
    checks++;
    if (err_addr !== 32'h0002_0000 || err_is_write !== 1'b0 || m_bus.bvalid !== 1'b0) begin
      failures++; $display("FAIL bound_sticky: got %h/%b bvalid=%b expected 00020000/0 0", err_addr, err_is_write, m_bus.bvalid);
    end
  endtask

  task automatic test_concurrent();
    bit ok1, ok2, ok3, ok4; logic [31:0] a, aa, d; logic [3:0] s;
    int s0w, s1r, rx, bx;
    s0w = s0_wr_act; s1r = s1_rd_act; rx = r_xfers; bx = b_xfers;
    m_bus.rready = 1'b1; m_bus.bready = 1'b1;
    fork
      m_ar(32'h0000_0200, ok1);
      m_aw(32'h2000_0000, 32'd123456789, 4'hF, ok2);
    join
    s_ar_accept(0, a, ok3);
    s_aw_accept(1, aa, d, s, ok4);
    checks++;
    if (!(ok1 && ok2 && ok3 && ok4) || a !== 32'h200 || aa !== 32'h2000_0000 || d !== 32'd123456789) begin
      failures++; $display("FAIL conc_fwd: got ok=%0d%0d%0d%0d ar=%h aw=%h d=%h expected 1111 00000200 20000000 075bcd15", ok1, ok2, ok3, ok4, a, aa, d);
    end
    s0_bus.rvalid = 1'b1; s0_bus.rdata = 32'h0000_BEEF;
    @(negedge clk);
    checks++;
    if (m_bus.rvalid !== 1'b1 || m_bus.rdata !== 32'h0000_BEEF || m_bus.bvalid !== 1'b0) begin
      failures++; $display("FAIL conc_read_first: got rv=%b rd=%h bv=%b expected 1 0000beef 0", m_bus.rvalid, m_bus.rdata, m_bus.bvalid);
    end
    step();
    s0_bus.rvalid = 1'b0;
    repeat (4) step();
    s1_bus.bvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (m_bus.bvalid !== 1'b1) begin
      failures++; $display("FAIL conc_bresp: got bvalid=%b expected 1", m_bus.bvalid);
    end
    step();
    s1_bus.bvalid = 1'b0;
    step();
    checks++;
    if (r_xfers - rx != 1 || b_xfers - bx != 1 || s0_wr_act != s0w || s1_rd_act != s1r) begin
      failures++; $display("FAIL conc_routing: got r=%0d b=%0d s0w=%0d s1r=%0d expected 1 1 0 0", r_xfers - rx, b_xfers - bx, s0_wr_act - s0w, s1_rd_act - s1r);
    end
  endtask

  task automatic test_backpressure();
    bit ok1, ok2; logic [31:0] a; int rx;
    m_bus.rready = 1'b0;
    m_ar(32'h0000_0300, ok1);
    s_ar_accept(0, a, ok2);
    s0_bus.rvalid = 1'b1; s0_bus.rdata = 32'hCAFE_F00D;
    rx = r_xfers;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (!ok1 || !ok2 || m_bus.rvalid !== 1'b1 || m_bus.rdata !== 32'hCAFE_F00D || s0_bus.rready !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d: got v=%b d=%h rr=%b expected 1 cafef00d 0", i, m_bus.rvalid, m_bus.rdata, s0_bus.rready);
      end
      step();
    end
    m_bus.rready = 1'b1;
    @(negedge clk);
    checks++;
    if (s0_bus.rready !== 1'b1) begin
      failures++; $display("FAIL bp_release: got rready=%b expected 1", s0_bus.rready);
    end
    step();
    s0_bus.rvalid = 1'b0;
    step(); step();
    checks++;
    if (r_xfers - rx != 1) begin
      failures++; $display("FAIL bp_one_beat: got %0d transfers expected 1", r_xfers - rx);
    end
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2, seen; logic [31:0] a;
    m_aw(32'h1000_0000, 32'h55, 4'hF, ok1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s1_bus.awvalid) begin seen = 1'b1; break; end
    end
    checks++;
    if (!ok1 || !seen) begin
      failures++; $display("FAIL rst_fwd_setup: got ok=%0d awvalid_seen=%0d expected 1 1", ok1, seen);
    end
    step();
    resetn = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (hs_outs() !== 15'd0 || decode_err !== 1'b0) begin
      failures++; $display("FAIL rst_mid: got hs=%b err=%b expected 0 0", hs_outs(), decode_err);
    end
    resetn = 1'b1;
    step();
    m_bus.rready = 1'b1;
    m_ar(32'h0000_0000, ok1);
    s_ar_accept(0, a, ok2);
    s0_bus.rvalid = 1'b1; s0_bus.rdata = 32'hA5A5_0000;
    @(negedge clk);
    checks++;
    if (!ok1 || !ok2 || a !== 32'h0 || m_bus.rvalid !== 1'b1 || m_bus.rdata !== 32'hA5A5_0000) begin
      failures++; $display("FAIL rst_then_read: got ok=%0d/%0d a=%h v=%b d=%h expected 1/1 0 1 a5a50000", ok1, ok2, a, m_bus.rvalid, m_bus.rdata);
    end
    step();
    s0_bus.rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (hs_outs() !== 15'd0) begin
      failures++; $display("FAIL rst_read_idle: got %b expected all 0", hs_outs());
    end
  endtask

  initial begin
    m_bus.awvalid = 0; m_bus.awaddr = 0; m_bus.awprot = 0;
    m_bus.wvalid = 0; m_bus.wdata = 0; m_bus.wstrb = 0; m_bus.bready = 0;
    m_bus.arvalid = 0; m_bus.araddr = 0; m_bus.arprot = 0; m_bus.rready = 0;
    s0_bus.awready = 0; s0_bus.wready = 0; s0_bus.bvalid = 0;
    s0_bus.arready = 0; s0_bus.rvalid = 0; s0_bus.rdata = 0;
    s1_bus.awready = 0; s1_bus.wready = 0; s1_bus.bvalid = 0;
    s1_bus.arready = 0; s1_bus.rvalid = 0; s1_bus.rdata = 0;
    test_reset();
    test_read();
    test_write();
    test_boundary();
    test_concurrent();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_lite_router.md
Name: axi_lite_router

Overview:
- 1-master / 2-slave AXI4-lite address router between the picorv32_axi master port and the simulation memory model and peripheral space.
- Slave 0 is the 128 KiB RAM model. Slave 1 is the MMIO region (console at 0x1000_0000, test-pass at 0x2000_0000).
- Unmapped accesses are terminated locally and flagged, so the bench does not $finish on out-of-bounds traffic.
- Read and write paths are independent FSMs, each with one outstanding transaction.

Parameters:
- MEM_BASE, 32'h0000_0000, slave 0 base address.
- MEM_SIZE, 32'h0002_0000, slave 0 size in bytes.
- PERIPH_BASE, 32'h1000_0000, slave 1 base address.
- PERIPH_SIZE, 32'h2000_0000, slave 1 size in bytes (covers 0x1000_0000..0x2FFF_FFFF).
- ERR_RDATA, 32'h0000_0000, read data returned for unmapped reads.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- m_axi_aw{valid,ready,addr,prot}  in/out/in/in  1/1/32/3  master write address channel
- m_axi_w{valid,ready,data,strb}  in/out/in/in  1/1/32/4  master write data channel
- m_axi_b{valid,ready}  out/in  1/1  master write response channel
- m_axi_ar{valid,ready,addr,prot}  in/out/in/in  1/1/32/3  master read address channel
- m_axi_r{valid,ready,data}  out/in/out  1/1/32  master read data channel
- sN_axi_aw{valid,ready,addr,prot}  out/in/out/out  1/1/32/3  slave N write address, N=0,1
- sN_axi_w{valid,ready,data,strb}  out/in/out/out  1/1/32/4  slave N write data
- sN_axi_b{valid,ready}  in/out  1/1  slave N write response
- sN_axi_ar{valid,ready,addr,prot}  out/in/out/out  1/1/32/3  slave N read address
- sN_axi_r{valid,ready,data}  in/out/in  1/1/32  slave N read data
- decode_err  out  1  sticky, set on the first unmapped access
- err_addr  out  32  address of the first unmapped access
- err_is_write  out  1  first unmapped access was a write

Behaviour:
- Reset (resetn=0 at posedge clk):
  - Both FSMs go to IDLE.
  - All m_*ready, m_*valid, s*_valid and s*_ready outputs are 0.
  - decode_err=0, err_addr=0, err_is_write=0.
  - Reset mid-transaction abandons it. The slaves share the same reset.
- Decode (combinational, unsigned 32-bit compare):
  - sel0 = addr-MEM_BASE < MEM_SIZE.
  - sel1 = addr-PERIPH_BASE < PERIPH_SIZE.
  - Neither = unmapped. sel0 has priority if the regions overlap.
- Read FSM, states R_IDLE, R_FWD, R_RESP, R_ERR:
  - R_IDLE: on m_arvalid, register m_arready<=1 for exactly one cycle. Latch araddr, arprot and sel. Go to R_FWD, or to R_ERR if unmapped.
  - R_FWD: sel slave arvalid=1 (registered), addr and prot from latch. Hold until that slave's arready, then go to R_RESP.
  - R_RESP: combinational pass-through. m_rvalid=s_rvalid[sel], m_rdata=s_rdata[sel], s_rready[sel]=m_rready. Go to R_IDLE when s_rvalid&&m_rready.
  - R_ERR: m_rvalid=1, m_rdata=ERR_RDATA. Go to R_IDLE on m_rready.
- Write FSM, states W_IDLE, W_FWD, W_RESP, W_ERR:
  - W_IDLE: accept only when m_awvalid&&m_wvalid. Pulse awready and wready together for one cycle. Latch addr, prot, data, strb and sel.
  - W_FWD: assert s_awvalid[sel] and s_wvalid[sel]. Each is dropped independently on its own handshake (aw_done/w_done flags). Go to W_RESP when both are done; simultaneous handshakes are allowed.
  - W_RESP: pass b through, same rule as R_RESP.
  - W_ERR: m_bvalid=1 until m_bready. No slave sees the transaction.
- Non-selected slave ports: valid=0, ready=0 at all times.
- Read and write may target different or the same slave concurrently. There is no arbitration between the two FSMs.
- Latency: request path adds 2 cycles (registered accept, registered forward). Response path adds 0 cycles.
- Error capture: on entry to R_ERR or W_ERR, if decode_err==0, set decode_err=1 and record err_addr and err_is_write. A simultaneous read and write error records the write. Cleared only by reset.
- Backpressure: the R/B payload must stay stable while m_*ready=0. Only one beat is transferred per transaction.

Decomposition:
- Package axi_lite_router_pkg holds:
  - the region constants,
  - read and write state enums,
  - a decode function returning {hit0,hit1}.
- Sub-module axi_lite_addr_decode: purely combinational, instanced once for AR and once for AW.
- FSMs stay in the top.

Test Plan:
- Read 0x0000_0100, s0 returns 0x1234_5678 after 3 cycles -> m_rdata=0x1234_5678, s1 ar/r untouched, decode_err=0.
- Write 0x1000_0000 data 0x41 strb 0001 -> s1 sees awaddr 0x1000_0000, wdata 0x41, strb 0001. s0 untouched. m_bvalid is asserted in the same cycle as s1_bvalid.
- Boundary: read 0x0001_FFFC -> routed to s0. Read 0x0002_0000 -> no slave valid, m_rdata=0, decode_err=1, err_addr=0x0002_0000, err_is_write=0. A later write to 0x3000_0000 leaves err_addr unchanged.
- Concurrent: read s0 and write 0x2000_0000 (data 123456789) to s1 in the same cycle, s1 bvalid delayed 5 cycles -> both complete, no cross-routing, read completes first.
- Backpressure: m_rready held 0 for 4 cycles while s0_rvalid=1 with 0xCAFE_F00D -> m_rdata stable, s0_rready=0, exactly one transfer.
- Reset during W_FWD (s1 awready withheld) -> next cycle all valids and readies are 0 and both FSMs are idle. A new read to 0x0 then completes normally.
